// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiplier, one partial product per clock, start/busy/done handshake.
// Optional build macro MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mult_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);
  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc_nxt;
  logic           last;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

`ifdef MULT_EARLY_TERM_EN
  // Leave RUN on the edge that consumes the highest set multiplier bit,
  // so latency is 1 + msb index of b (b=0 also finishes after one edge).
  assign last = (cnt == LAST) || (mplier[N-1:1] == '0);
`else
  assign last = (cnt == LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Result must include this edge's partial product.
            result <= acc_nxt;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
